// File: rtl/merge5_if.sv
// Valid/ready channel used for the child, select-token and upward ports of merge5.
interface merge5_if #(
    parameter int unsigned W = 9
) ();
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/merge5.sv
// Two-to-one round-robin merge node: emits a 1-bit source token on S, then forwards
// the accepted packet unchanged on Out. Address bits are carried but never decoded.
module merge5 #(
    parameter int unsigned W         = 9,
    parameter bit          FIRST_PRI = 1'b0
) (
    input  logic     CLK,
    input  logic     _RESET,
    merge5_if.slave  In0,
    merge5_if.slave  In1,
    merge5_if.master S,
    merge5_if.master Out
);

    typedef enum logic [1:0] {StIdle, StSendS, StSendOut} state_e;

    state_e       state_q, state_d;
    logic [W-1:0] hold_q, hold_d;
    logic         g_q, g_d;
    logic         last_q, last_d;
    logic         w;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        g_d       = g_q;
        last_d    = last_q;
        In0.ready = 1'b0;
        In1.ready = 1'b0;
        S.valid   = 1'b0;
        S.data    = '0;
        Out.valid = 1'b0;
        Out.data  = '0;
        // Tie goes to the child that did not win last; a lone requester always wins.
        w = (In0.valid && In1.valid) ? ~last_q : In1.valid;

        // Outputs are forced low while reset is asserted so nothing completes on that edge.
        if (!_RESET) begin
            unique case (state_q)
                StIdle: begin
                    if (In0.valid || In1.valid) begin
                        In0.ready = ~w;
                        In1.ready = w;
                        hold_d    = w ? In1.data : In0.data;
                        g_d       = w;
                        last_d    = w;
                        state_d   = StSendS;
                    end
                end
                StSendS: begin
                    S.valid = 1'b1;
                    S.data  = g_q;
                    if (S.ready) state_d = StSendOut;
                end
                StSendOut: begin
                    Out.valid = 1'b1;
                    Out.data  = hold_q;
                    if (Out.ready) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (_RESET) begin
            state_q <= StIdle;
            hold_q  <= '0;
            g_q     <= 1'b0;
            last_q  <= ~FIRST_PRI;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            g_q     <= g_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_merge5.sv
// Directed and soak checks for merge5: reset, single child, contention, backpressure,
// mid-packet reset and a scoreboarded random run.
module tb_merge5;

    logic CLK = 1'b0;
    logic _RESET;
    always #5 CLK = ~CLK;

    merge5_if #(.W(9)) in0_if ();
    merge5_if #(.W(9)) in1_if ();
    merge5_if #(.W(1)) s_if ();
    merge5_if #(.W(9)) out_if ();

    merge5 #(.W(9), .FIRST_PRI(1'b0)) dut (
        .CLK    (CLK),
        ._RESET (_RESET),
        .In0    (in0_if),
        .In1    (in1_if),
        .S      (s_if),
        .Out    (out_if)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge CLK);
        #1;
    endtask

    // A child dropping valid before its handshake breaks the protocol.
    logic pend0 = 1'b0;
    logic pend1 = 1'b0;
    always @(posedge CLK) begin
        if (pend0) assert (in0_if.valid) else begin
            n_mis++;
            $error("FAIL proto0: valid observed 0 expected 1");
        end
        if (pend1) assert (in1_if.valid) else begin
            n_mis++;
            $error("FAIL proto1: valid observed 0 expected 1");
        end
        pend0 <= in0_if.valid && !in0_if.ready && !_RESET;
        pend1 <= in1_if.valid && !in1_if.ready && !_RESET;
    end

    logic [8:0]  q0[$];
    logic [8:0]  q1[$];
    logic [7:0]  seq0, seq1;
    logic        tok, tok_pend, tb_last, winner, gen, a0, a1;
    logic [15:0] expd;

    initial begin
        _RESET = 1'b1;
        in0_if.valid = 1'b0; in0_if.data = '0;
        in1_if.valid = 1'b0; in1_if.data = '0;
        s_if.ready = 1'b0;   out_if.ready = 1'b0;

        // Reset, with a request offered during reset that must not be accepted.
        next();
        in0_if.valid = 1'b1; in0_if.data = 9'h1A5;
        #2 chk("rst_in0_ready", in0_if.ready, 0);
        chk("rst_s_valid", s_if.valid, 0);
        next();
        _RESET = 1'b0;
        in0_if.valid = 1'b0;
        #2 chk("idle_s_valid", s_if.valid, 0);
        chk("idle_out_valid", out_if.valid, 0);
        chk("idle_in0_ready", in0_if.ready, 0);
        chk("idle_in1_ready", in1_if.ready, 0);
        chk("idle_s_data", s_if.data, 0);
        chk("idle_out_data", out_if.data, 0);
        next();

        // Single child, sinks always ready.
        s_if.ready = 1'b1; out_if.ready = 1'b1;
        in0_if.valid = 1'b1; in0_if.data = 9'h1A5;
        #2 chk("single_in0_ready", in0_if.ready, 1);
        chk("single_in1_ready", in1_if.ready, 0);
        next();
        in0_if.valid = 1'b0;
        #2 chk("single_s_valid", s_if.valid, 1);
        chk("single_s_data", s_if.data, 0);
        chk("single_out_valid_c1", out_if.valid, 0);
        next();
        #2 chk("single_out_valid", out_if.valid, 1);
        chk("single_out_data", out_if.data, 9'h1A5);
        chk("single_s_valid_c2", s_if.valid, 0);
        next();
        #2 chk("single_done_out", out_if.valid, 0);
        chk("single_done_s", s_if.valid, 0);
        next();

        // Contention straight after reset: grants alternate starting with In0.
        _RESET = 1'b1;
        next();
        _RESET = 1'b0;
        in0_if.valid = 1'b1; in0_if.data = 9'h0F0;
        in1_if.valid = 1'b1; in1_if.data = 9'h1F1;
        for (int k = 0; k < 8; k++) begin
            #2 chk("cont_in0_ready", in0_if.ready, (k % 2 == 0) ? 16'd1 : 16'd0);
            chk("cont_in1_ready", in1_if.ready, (k % 2 == 1) ? 16'd1 : 16'd0);
            next();
            if (k == 6) in0_if.valid = 1'b0;
            if (k == 7) in1_if.valid = 1'b0;
            #2 chk("cont_s_data", s_if.data, (k % 2 == 1) ? 16'd1 : 16'd0);
            next();
            #2 chk("cont_out_data", out_if.data, (k % 2 == 1) ? 16'h1F1 : 16'h0F0);
            next();
        end

        // Backpressure on S then on Out, with In0 waiting throughout.
        s_if.ready = 1'b0; out_if.ready = 1'b0;
        in1_if.valid = 1'b1; in1_if.data = 9'h0AA;
        #2 chk("bp_in1_ready", in1_if.ready, 1);
        next();
        in1_if.valid = 1'b0;
        in0_if.valid = 1'b1; in0_if.data = 9'h033;
        for (int k = 0; k < 5; k++) begin
            #2 chk("bp_s_valid", s_if.valid, 1);
            chk("bp_s_data", s_if.data, 1);
            chk("bp_s_in0_ready", in0_if.ready, 0);
            chk("bp_s_out_valid", out_if.valid, 0);
            next();
        end
        s_if.ready = 1'b1;
        #2 chk("bp_s_release", s_if.valid, 1);
        next();
        s_if.ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #2 chk("bp_out_valid", out_if.valid, 1);
            chk("bp_out_data", out_if.data, 9'h0AA);
            chk("bp_out_s_valid", s_if.valid, 0);
            chk("bp_out_in0_ready", in0_if.ready, 0);
            next();
        end
        out_if.ready = 1'b1; s_if.ready = 1'b1;
        #2 chk("bp_out_release", out_if.valid, 1);
        next();
        #2 chk("bp_next_in0_ready", in0_if.ready, 1);
        next();
        in0_if.valid = 1'b0;
        #2 chk("bp_next_s_data", s_if.data, 0);
        next();
        #2 chk("bp_next_out_data", out_if.data, 9'h033);
        next();

        // Reset while 0x155 is waiting in SEND_OUT.
        out_if.ready = 1'b0;
        in0_if.valid = 1'b1; in0_if.data = 9'h155;
        #2 chk("mid_in0_ready", in0_if.ready, 1);
        next();
        in0_if.valid = 1'b0;
        #2 chk("mid_s_valid", s_if.valid, 1);
        next();
        #2 chk("mid_out_held", out_if.data, 9'h155);
        _RESET = 1'b1; out_if.ready = 1'b1;
        #2 chk("mid_rst_out_valid", out_if.valid, 0);
        next();
        _RESET = 1'b0;
        in1_if.valid = 1'b1; in1_if.data = 9'h0C3;
        #2 chk("mid_after_out_valid", out_if.valid, 0);
        chk("mid_after_s_valid", s_if.valid, 0);
        chk("mid_after_in1_ready", in1_if.ready, 1);
        next();
        in1_if.valid = 1'b0;
        #2 chk("mid_tok_first_s", s_if.valid, 1);
        chk("mid_tok_first_data", s_if.data, 1);
        chk("mid_tok_first_out", out_if.valid, 0);
        next();
        #2 chk("mid_new_out_data", out_if.data, 9'h0C3);
        next();

        // Random soak with per-child scoreboards; last accept above came from In1.
        tb_last = 1'b1; tok_pend = 1'b0; tok = 1'b0;
        seq0 = '0; seq1 = '0;
        for (int c = 0; c < 2020; c++) begin
            gen = (c < 2000);
            if (gen && !in0_if.valid && $urandom_range(0, 2) != 0) begin
                in0_if.valid = 1'b1; in0_if.data = {1'b0, seq0}; seq0++;
            end
            if (gen && !in1_if.valid && $urandom_range(0, 2) != 0) begin
                in1_if.valid = 1'b1; in1_if.data = {1'b1, seq1}; seq1++;
            end
            s_if.ready   = gen ? 1'($urandom_range(0, 1)) : 1'b1;
            out_if.ready = gen ? 1'($urandom_range(0, 1)) : 1'b1;
            #2;
            a0 = in0_if.valid && in0_if.ready;
            a1 = in1_if.valid && in1_if.ready;
            if (a0 || a1) begin
                chk("soak_onehot", {15'd0, a0 && a1}, 0);
                winner = a1;
                if (in0_if.valid && in1_if.valid) chk("soak_alt", winner, !tb_last);
                tb_last = winner;
                if (a0) q0.push_back(in0_if.data);
                if (a1) q1.push_back(in1_if.data);
            end
            if (out_if.valid && out_if.ready) begin
                chk("soak_tok_before_out", tok_pend, 1);
                expd = 16'hFFFF;
                if (tok && q1.size() > 0) expd = {7'd0, q1.pop_front()};
                else if (!tok && q0.size() > 0) expd = {7'd0, q0.pop_front()};
                chk("soak_out_data", out_if.data, expd);
                tok_pend = 1'b0;
            end
            if (s_if.valid && s_if.ready) begin
                chk("soak_single_tok", tok_pend, 0);
                tok = s_if.data;
                tok_pend = 1'b1;
            end
            next();
            if (a0) in0_if.valid = 1'b0;
            if (a1) in1_if.valid = 1'b0;
        end
        chk("soak_q0_drained", q0.size(), 0);
        chk("soak_q1_drained", q1.size(), 0);
        chk("soak_tok_drained", tok_pend, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
